// File: rtl/conv_pkg.sv
// Shared types, default dimensions and width helper for the convolution controller.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } ctrl_state_t;

  localparam int unsigned DEF_FEATURE_MAP_WIDTH  = 4;
  localparam int unsigned DEF_FEATURE_MAP_HEIGHT = 4;
  localparam int unsigned DEF_INPUT_NB_CHANNELS  = 2;
  localparam int unsigned DEF_OUTPUT_NB_CHANNELS = 2;
  localparam int unsigned DEF_KERNEL_SIZE        = 3;
  localparam int unsigned DEF_MAC_LATENCY        = 2;

  // Coordinate width; a count of 1 still needs a 1-bit (constant zero) field.
  function automatic int unsigned coord_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with increment/clear and a registered count; at_max flags the last value.
module wrap_counter
  import conv_pkg::*;
#(
  parameter int unsigned MODULUS = 2,
  parameter int unsigned WIDTH   = coord_w(MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_q, count_d;

  assign at_max = (count_q == WIDTH'(MODULUS - 1));
  assign count  = count_q;

  // Next count: clear wins, otherwise wrap to zero after the last value.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = at_max ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv_loop_controller.sv
// Loop-nest sequencer for the 3-tap convolution datapath: fetch, drain, output per pixel.
// Optional build macro CONV_CTRL_PERF_EN adds perf_cycles / perf_stalls counters.
module conv_loop_controller
  import conv_pkg::*;
#(
  parameter int unsigned FEATURE_MAP_WIDTH  = DEF_FEATURE_MAP_WIDTH,
  parameter int unsigned FEATURE_MAP_HEIGHT = DEF_FEATURE_MAP_HEIGHT,
  parameter int unsigned INPUT_NB_CHANNELS  = DEF_INPUT_NB_CHANNELS,
  parameter int unsigned OUTPUT_NB_CHANNELS = DEF_OUTPUT_NB_CHANNELS,
  parameter int unsigned KERNEL_SIZE        = DEF_KERNEL_SIZE,
  parameter int unsigned MAC_LATENCY        = DEF_MAC_LATENCY
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      running,
  input  logic                                      a_valid,
  output logic                                      a_ready,
  input  logic                                      b_valid,
  output logic                                      b_ready,
  output logic                                      mac_en,
  output logic                                      mac_clear,
  output logic [coord_w(INPUT_NB_CHANNELS)-1:0]     fetch_ch_in,
  output logic [coord_w(KERNEL_SIZE)-1:0]           fetch_ky,
  output logic                                      output_valid,
  output logic [coord_w(FEATURE_MAP_WIDTH)-1:0]     output_x,
  output logic [coord_w(FEATURE_MAP_HEIGHT)-1:0]    output_y,
  output logic [coord_w(OUTPUT_NB_CHANNELS)-1:0]    output_ch,
  output logic                                      done
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [31:0]                               perf_cycles,
  output logic [31:0]                               perf_stalls
`endif
);

  localparam int unsigned DRN_W = coord_w(MAC_LATENCY);

  ctrl_state_t      state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             running_q, running_d;
  logic             ready_q, ready_d;
  logic             ovalid_q, ovalid_d;
  logic             done_q, done_d;

  logic fire, last_fetch, pix_adv, last_pix, cnt_clr;
  logic ky_max, cin_max, x_max, y_max, co_max;

  // Joint handshake: a fetch happens only when both rows are offered in FETCH.
  assign fire       = a_valid && b_valid && (state_q == FETCH);
  assign mac_en     = fire;
  assign mac_clear  = fire && (fetch_ch_in == '0) && (fetch_ky == '0);
  assign last_fetch = fire && ky_max && cin_max;
  assign pix_adv    = (state_q == OUTPUT);
  assign last_pix   = x_max && y_max && co_max;
  assign cnt_clr    = (state_q == IDLE);

  wrap_counter #(.MODULUS(KERNEL_SIZE)) u_ky (
    .clk(clk), .rst(rst), .inc(fire), .clr(cnt_clr), .count(fetch_ky), .at_max(ky_max)
  );
  wrap_counter #(.MODULUS(INPUT_NB_CHANNELS)) u_cin (
    .clk(clk), .rst(rst), .inc(fire && ky_max), .clr(cnt_clr), .count(fetch_ch_in),
    .at_max(cin_max)
  );
  wrap_counter #(.MODULUS(FEATURE_MAP_WIDTH)) u_x (
    .clk(clk), .rst(rst), .inc(pix_adv), .clr(cnt_clr), .count(output_x), .at_max(x_max)
  );
  wrap_counter #(.MODULUS(FEATURE_MAP_HEIGHT)) u_y (
    .clk(clk), .rst(rst), .inc(pix_adv && x_max), .clr(cnt_clr), .count(output_y),
    .at_max(y_max)
  );
  wrap_counter #(.MODULUS(OUTPUT_NB_CHANNELS)) u_co (
    .clk(clk), .rst(rst), .inc(pix_adv && x_max && y_max), .clr(cnt_clr), .count(output_ch),
    .at_max(co_max)
  );

  // Next state, drain countdown and Moore outputs derived from the next state.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (last_fetch) begin
          state_d = DRAIN;
          drain_d = DRN_W'(MAC_LATENCY - 1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = OUTPUT;
        else               drain_d = drain_q - DRN_W'(1);
      end
      OUTPUT: begin
        if (last_pix) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d != IDLE);
    ready_d   = (state_d == FETCH);
    ovalid_d  = (state_d == OUTPUT);
  end

  // State and registered output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      running_q <= 1'b0;
      ready_q   <= 1'b0;
      ovalid_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      running_q <= running_d;
      ready_q   <= ready_d;
      ovalid_q  <= ovalid_d;
      done_q    <= done_d;
    end
  end

  assign running      = running_q;
  assign a_ready      = ready_q;
  assign b_ready      = ready_q;
  assign output_valid = ovalid_q;
  assign done         = done_q;

`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Saturating busy/stall counters, restarted on each launch.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if ((state_q == IDLE) && start) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (running_q && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
      if ((state_q == FETCH) && !fire && (perf_stalls_q != '1))
        perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_conv_loop_controller.sv
// Self-checking bench: cycle-level reference model built from pixel/fetch arithmetic.
module tb_conv_loop_controller;
  import conv_pkg::*;

  localparam int W = 2, H = 2, CI = 2, CO = 2, K = 3, ML = 2;
  localparam int F = CI * K;
  localparam int NPIX = W * H * CO;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, a_valid, b_valid;
  logic running, a_ready, b_ready, mac_en, mac_clear, output_valid, done;
  logic [coord_w(CI)-1:0] fetch_ch_in;
  logic [coord_w(K)-1:0]  fetch_ky;
  logic [coord_w(W)-1:0]  output_x;
  logic [coord_w(H)-1:0]  output_y;
  logic [coord_w(CO)-1:0] output_ch;
`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stalls, perf_cycles1, perf_stalls1;
`endif

  // Second instance: single-channel, single-row kernel, latency 1.
  logic start1, a1, b1;
  logic running1, a_ready1, b_ready1, mac_en1, mac_clear1, ov1, done1;
  logic [0:0] fch1, fky1, ox1, oy1, och1;

  conv_loop_controller #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(CI),
    .OUTPUT_NB_CHANNELS(CO), .KERNEL_SIZE(K), .MAC_LATENCY(ML)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .running(running),
    .a_valid(a_valid), .a_ready(a_ready), .b_valid(b_valid), .b_ready(b_ready),
    .mac_en(mac_en), .mac_clear(mac_clear), .fetch_ch_in(fetch_ch_in), .fetch_ky(fetch_ky),
    .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
    .output_ch(output_ch), .done(done)
`ifdef CONV_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  conv_loop_controller #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .INPUT_NB_CHANNELS(1),
    .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(1), .MAC_LATENCY(1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .running(running1),
    .a_valid(a1), .a_ready(a_ready1), .b_valid(b1), .b_ready(b_ready1),
    .mac_en(mac_en1), .mac_clear(mac_clear1), .fetch_ch_in(fch1), .fetch_ky(fky1),
    .output_valid(ov1), .output_x(ox1), .output_y(oy1), .output_ch(och1), .done(done1)
`ifdef CONV_CTRL_PERF_EN
    , .perf_cycles(perf_cycles1), .perf_stalls(perf_stalls1)
`endif
  );

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: run flag, fetches done in current pixel, drain cycles left, linear pixel.
  bit m_run = 0, m_done = 0;
  int m_fd = 0, m_dl = 0, m_pix = 0;
  int unsigned m_cyc = 0, m_stall = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_done = 0; m_fd = 0; m_dl = 0; m_pix = 0; m_cyc = 0; m_stall = 0;
    end else begin
      m_done = 0;
      if (m_run) begin
        if (m_cyc != 32'hffff_ffff) m_cyc++;
        if (m_fd < F && !(a_valid && b_valid) && m_stall != 32'hffff_ffff) m_stall++;
      end
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_fd = 0; m_dl = ML; m_cyc = 0; m_stall = 0;
        end
      end else if (m_fd < F) begin
        if (a_valid && b_valid) m_fd++;
      end else if (m_dl > 0) begin
        m_dl--;
      end else begin
        m_fd = 0; m_dl = ML;
        if (m_pix == NPIX - 1) begin
          m_pix = 0; m_run = 0; m_done = 1;
        end else begin
          m_pix++;
        end
      end
    end
  end

  int n_ov = 0, n_run = 0, n_clr = 0, n_done = 0, n_ov1 = 0, n_run1 = 0;

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    bit fe, fire;
    @(negedge clk);
    fe   = m_run && (m_fd < F);
    fire = fe && a_valid && b_valid;
    check("running", 32'(running), 32'(m_run));
    check("a_ready", 32'(a_ready), 32'(fe));
    check("b_ready", 32'(b_ready), 32'(fe));
    check("mac_en", 32'(mac_en), 32'(fire));
    check("mac_clear", 32'(mac_clear), 32'(fire && m_fd == 0));
    check("fetch_ky", 32'(fetch_ky), fe ? 32'(m_fd % K) : 32'd0);
    check("fetch_ch_in", 32'(fetch_ch_in), fe ? 32'(m_fd / K) : 32'd0);
    check("output_valid", 32'(output_valid), 32'(m_run && m_fd == F && m_dl == 0));
    check("output_x", 32'(output_x), 32'(m_pix % W));
    check("output_y", 32'(output_y), 32'((m_pix / W) % H));
    check("output_ch", 32'(output_ch), 32'(m_pix / (W * H)));
    check("done", 32'(done), 32'(m_done));
`ifdef CONV_CTRL_PERF_EN
    check("perf_cycles", perf_cycles, m_cyc);
    check("perf_stalls", perf_stalls, m_stall);
`endif
    n_ov += int'(output_valid); n_run += int'(running);
    n_clr += int'(mac_clear); n_done += int'(done);
    // Small instance: every accumulate is a load, fetch counters pinned to zero.
    if (mac_en1) check("s5_clear_with_en", 32'(mac_clear1), 32'd1);
    if (running1) begin
      check("s5_fetch_ky", 32'(fky1), 32'd0);
      check("s5_fetch_ch", 32'(fch1), 32'd0);
      check("s5_b_ready", 32'(b_ready1), 32'(a_ready1));
    end
    if (ov1) begin
      check("s5_coord", 32'({och1, oy1, ox1}), 32'(n_ov1));
      n_ov1++;
    end
    n_run1 += int'(running1);
    if (done1) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_ov = 0; n_run = 0; n_clr = 0; n_done = 0;
  endtask

  // Step until done (optionally randomising valids/start); expiry counts as a failure.
  task automatic run_to_done(input string tag, input bit rnd_valid, input bit rnd_start);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (rnd_valid) begin
        a_valid = ($urandom_range(0, 3) != 0);
        b_valid = ($urandom_range(0, 3) != 0);
      end
      if (rnd_start) start = $urandom_range(0, 1) == 1;
      step();
      seen = done;
    end
    start = 0;
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    a_valid = 1; b_valid = 1;
    step();
  endtask

  initial begin
    rst = 1; start = 0; a_valid = 0; b_valid = 0; start1 = 0; a1 = 0; b1 = 0;
    repeat (3) step();
    check("reset_running", 32'(running), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 0;
    step();

    // S1: valids held high, single launch.
    clear_counts();
    a_valid = 1; b_valid = 1; start = 1;
    step();
    start = 0;
    run_to_done("s1", 0, 0);
    check("s1_outputs", n_ov, 8);
    check("s1_running_cycles", n_run, 72);
    check("s1_done", n_done, 1);
    check("s1_clears", n_clr, 8);

    // S2: b_valid drops for three cycles mid-pixel.
    clear_counts();
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 200 && !(m_pix == 1 && m_fd == 2); i++) step();
    check("s2_reached_midpixel", 32'(m_pix == 1 && m_fd == 2), 32'd1);
    b_valid = 0;
    repeat (3) step();
    b_valid = 1;
    run_to_done("s2", 0, 0);
    check("s2_running_cycles", n_run, 75);
`ifdef CONV_CTRL_PERF_EN
    check("s2_perf_stalls", perf_stalls, 32'd3);
    check("s2_perf_cycles", perf_cycles, 32'd75);
`endif

    // S3: random valids, start re-pulsed randomly while running.
    clear_counts();
    start = 1;
    step();
    run_to_done("s3", 1, 1);
    check("s3_outputs", n_ov, 8);
    check("s3_done", n_done, 1);

    // S4: reset during drain of pixel 3, then restart from the origin.
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 2000 && !(m_pix == 3 && m_fd == F && m_dl > 0); i++) begin
      a_valid = ($urandom_range(0, 1) == 1);
      b_valid = ($urandom_range(0, 1) == 1);
      step();
    end
    check("s4_reached_drain", 32'(m_pix == 3 && m_fd == F && m_dl > 0), 32'd1);
    clear_counts();
    rst = 1;
    step();
    rst = 0;
    check("s4_abort_running", 32'(running), 32'd0);
    check("s4_abort_coords", 32'({output_ch, output_y, output_x}), 32'd0);
    repeat (5) step();
    check("s4_no_done", n_done, 0);
    check("s4_no_output", n_ov, 0);
    a_valid = 1; b_valid = 1; start = 1;
    step();
    start = 0;
    run_to_done("s4", 0, 0);
    check("s4_restart_outputs", n_ov, 8);

    // S5: degenerate reduction loop on the second instance.
    clear_counts();
    a1 = 1; b1 = 1; start1 = 1;
    step();
    start1 = 0;
    for (int i = 0; i < 200 && !done1; i++) step();
    check("s5_done_seen", 32'(done1), 32'd1);
    step();
    check("s5_running_cycles", n_run1, 24);
    check("s5_outputs", n_ov1, 8);
    check("s5_done_count", n_done, 1);
`ifdef CONV_CTRL_PERF_EN
    check("s5_perf_cycles", perf_cycles1, 32'd24);
    check("s5_perf_stalls", perf_stalls1, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
